// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding, widths
// and the rotating-priority search helper.
package rr_arbiter8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned HOLD_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set request bit scanning ptr, ptr+1, ... modulo NUM_REQ; 0 if none.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win;
    logic             found;
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 binary to one-hot decoder.
module decoder3_8
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered grant, one dead cycle
// between owners, and hold-time preemption after MAX_HOLD cycles.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;

  logic [IDX_W-1:0]    winner;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [NUM_REQ-1:0]  others;
  logic                hold_at_limit;

  decoder3_8 u_dec (
    .idx    (idx_q),
    .onehot (owner_oh)
  );

  assign winner        = rr_pick(req, ptr_q);
  assign others        = req & ~owner_oh;
  assign hold_at_limit = (hold_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = winner;
          valid_d = 1'b1;
          ptr_d   = winner + IDX_W'(1);
          hold_d  = '0;
        end else begin
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        // Release and preemption lead to the same exit, so one branch covers both.
        if (!req[idx_q] || (hold_at_limit && (|others))) begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else if (!hold_at_limit) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign gnt       = owner_oh & {NUM_REQ{valid_q}};
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed scoreboard bench for rr_arbiter8 built with MAX_HOLD=4.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
  } exp_t;

  exp_t sb[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: got 0 entries expected >=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (gnt === e.gnt) else begin
        errors++;
        $error("FAIL %s gnt: got %h expected %h", e.tag, gnt, e.gnt);
      end
      checks++;
      assert (gnt_idx === idx_of(e.gnt)) else begin
        errors++;
        $error("FAIL %s gnt_idx: got %0d expected %0d", e.tag, gnt_idx, idx_of(e.gnt));
      end
      checks++;
      assert (gnt_valid === (e.gnt != 8'h00)) else begin
        errors++;
        $error("FAIL %s gnt_valid: got %b expected %b", e.tag, gnt_valid, (e.gnt != 8'h00));
      end
      checks++;
      assert ($onehot0(gnt)) else begin
        errors++;
        $error("FAIL %s onehot: got %h expected at most one bit", e.tag, gnt);
      end
    end
  endtask

  // Drive rst/req for the next edge, record expected outputs, compare after it.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] eg,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.tag = tag;
    e.gnt = eg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // Reset, including reset overriding active requests
    step(1'b1, 8'h00, 8'h00, "reset");
    step(1'b1, 8'hFF, 8'h00, "reset_req");
    checks++;
    assert (dut.ptr_q === 3'd0) else begin
      errors++;
      $error("FAIL reset_ptr: got %0d expected 0", dut.ptr_q);
    end

    // Single request
    step(1'b0, 8'h10, 8'h10, "single");
    step(1'b0, 8'h10, 8'h10, "single_hold");
    step(1'b0, 8'h00, 8'h00, "single_rel");
    step(1'b0, 8'h00, 8'h00, "idle");

    // Round-robin order with all requesters active
    step(1'b1, 8'h00, 8'h00, "rr_reset");
    for (int w = 0; w < 8; w++) begin
      for (int c = 0; c < 3; c++) step(1'b0, 8'hFF, 8'(1) << w, "rr_own");
      step(1'b0, 8'hFF & ~(8'(1) << w), 8'h00, "rr_dead");
    end
    for (int c = 0; c < 3; c++) step(1'b0, 8'hFF, 8'h01, "rr_wrap_own");
    step(1'b0, 8'h00, 8'h00, "rr_end");

    // Preemption after MAX_HOLD cycles
    step(1'b1, 8'h00, 8'h00, "pre_reset");
    for (int c = 0; c < 4; c++) step(1'b0, 8'h24, 8'h04, "pre_own2");
    step(1'b0, 8'h24, 8'h00, "pre_dead");
    step(1'b0, 8'h24, 8'h20, "pre_own5");
    step(1'b0, 8'h00, 8'h00, "pre_rel");

    // Saturated hold counter, then preemption as soon as another requester appears
    for (int c = 0; c < 10; c++) step(1'b0, 8'h08, 8'h08, "sat_own3");
    step(1'b0, 8'h48, 8'h00, "sat_dead");
    step(1'b0, 8'h48, 8'h40, "sat_own6");
    step(1'b0, 8'h00, 8'h00, "sat_rel");

    // Wrap-around from owner 7 to owner 0
    step(1'b0, 8'h80, 8'h80, "wrap_own7");
    step(1'b0, 8'h81, 8'h80, "wrap_hold7");
    step(1'b0, 8'h01, 8'h00, "wrap_dead");
    step(1'b0, 8'h81, 8'h01, "wrap_own0");
    checks++;
    assert (dut.ptr_q === 3'd1) else begin
      errors++;
      $error("FAIL wrap_ptr: got %0d expected 1", dut.ptr_q);
    end
    step(1'b0, 8'h00, 8'h00, "wrap_rel");

    // Reset during ownership
    step(1'b0, 8'h21, 8'h20, "rst_own5");
    step(1'b0, 8'h21, 8'h20, "rst_hold5");
    step(1'b1, 8'h21, 8'h00, "rst_mid");
    step(1'b0, 8'h21, 8'h01, "rst_own0");
    step(1'b0, 8'h00, 8'h00, "rst_rel");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
